// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two core ports, the arbiter and the seven slaves.
// The arbiter uses the slave view; the core/slave side uses the master view.
interface mem_bus_arbiter_if;
  logic [1:0]        req_i;
  logic [1:0][31:0]  addr_i;
  logic [1:0]        we_i;
  logic [1:0][3:0]   be_i;
  logic [1:0][31:0]  wdata_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic [31:0]       rdata_o;
  logic              err_o;
  logic [6:0]        slv_req_o;
  logic [31:0]       slv_addr_o;
  logic              slv_we_o;
  logic [3:0]        slv_be_o;
  logic [31:0]       slv_wdata_o;
  logic [6:0][31:0]  slv_rdata_i;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, slv_rdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
           slv_req_o, slv_addr_o, slv_we_o, slv_be_o, slv_wdata_o
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, slv_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
           slv_req_o, slv_addr_o, slv_we_o, slv_be_o, slv_wdata_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter with address decode onto seven slaves and
// per-slave wait-state sequencing; one access in flight at a time.
//
// state | meaning
// IDLE  | no access in flight, grant allowed
// ISSUE | one-cycle slave request pulse for the latched access
// WAIT  | counting down the slave's wait states
// RESP  | response to the latched master, grant allowed (back-to-back)
module mem_bus_arbiter #(
  parameter bit          RR_EN       = 1'b1,
  parameter int unsigned LAT_BOOTROM = 1,
  parameter int unsigned LAT_PERIPH  = 0,
  parameter int unsigned LAT_RAM     = 7,
  parameter int unsigned LAT_FB      = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mst_q, last_q, we_q, hit_q;
  logic [2:0]  sel_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic [1:0]  gnt;
  logic        gnt_any, gnt_mst;
  logic [31:0] gnt_addr;
  logic [2:0]  dec_sel;
  logic        dec_hit;
  logic [31:0] rd_mux;

  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [6:0]  slv_req;

  function automatic logic [7:0] lat_of(input logic [2:0] s);
    case (s)
      3'd0:                   return 8'(LAT_BOOTROM);
      3'd1, 3'd2, 3'd3, 3'd4: return 8'(LAT_PERIPH);
      3'd5:                   return 8'(LAT_RAM);
      default:                return 8'(LAT_FB);
    endcase
  endfunction

  // last_q = 1 means M1 was granted last, so M0 wins the first tie after reset
  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE || state_q == RESP) begin
      case (bus.req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (RR_EN && !last_q) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_any  = |gnt;
  assign gnt_mst  = gnt[1];
  assign gnt_addr = bus.addr_i[gnt_mst];

  // Slaves 1-4 are consecutive 4 KiB windows, so addr[13:12] picks among them
  always_comb begin
    dec_hit = 1'b1;
    dec_sel = 3'd0;
    if (gnt_addr >= 32'h1A00_0000 && gnt_addr <= 32'h1A00_1FFF)
      dec_sel = 3'd0;
    else if (gnt_addr >= 32'h1B00_0000 && gnt_addr <= 32'h1B00_3FFF)
      dec_sel = 3'd1 + {1'b0, gnt_addr[13:12]};
    else if (gnt_addr >= 32'h1C00_0000 && gnt_addr <= 32'h1C00_FFFF)
      dec_sel = 3'd5;
    else if (gnt_addr >= 32'h1D00_0000 && gnt_addr <= 32'h1D03_FFFF)
      dec_sel = 3'd6;
    else
      dec_hit = 1'b0;
  end

  always_comb begin
    rd_mux = 32'h0;
    for (int i = 0; i < 7; i++) begin
      if (sel_q == 3'(i)) rd_mux = bus.slv_rdata_i[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rvalid  = 2'b00;
    rdata   = 32'h0;
    err     = 1'b0;
    slv_req = 7'h00;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = ISSUE;
          cnt_d   = dec_hit ? lat_of(dec_sel) : 8'd0;
        end
      end
      ISSUE: begin
        if (hit_q) slv_req = 7'b000_0001 << sel_q;
        state_d = (!hit_q || cnt_q == 8'd0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = RESP;
      end
      RESP: begin
        rvalid = mst_q ? 2'b10 : 2'b01;
        err    = !hit_q;
        rdata  = (hit_q && !we_q) ? rd_mux : 32'h0;
        if (gnt_any) begin
          state_d = ISSUE;
          cnt_d   = dec_hit ? lat_of(dec_sel) : 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mst_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      sel_q   <= 3'd0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
    end else if (gnt_any) begin
      mst_q   <= gnt_mst;
      last_q  <= gnt_mst;
      we_q    <= bus.we_i[gnt_mst];
      hit_q   <= dec_hit;
      sel_q   <= dec_sel;
      addr_q  <= gnt_addr;
      be_q    <= bus.be_i[gnt_mst];
      wdata_q <= bus.wdata_i[gnt_mst];
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.rvalid_o    = rvalid;
  assign bus.rdata_o     = rdata;
  assign bus.err_o       = err;
  assign bus.slv_req_o   = slv_req;
  assign bus.slv_addr_o  = addr_q;
  assign bus.slv_we_o    = we_q;
  assign bus.slv_be_o    = be_q;
  assign bus.slv_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a table of single accesses plus
// sequences for back-to-back arbitration, fixed priority and mid-access reset.
module tb_mem_bus_arbiter;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  mem_bus_arbiter_if br ();
  mem_bus_arbiter_if bf ();

  mem_bus_arbiter #(.RR_EN(1'b1)) dut_rr (.clk_i(clk_i), .rst_ni(rst_ni), .bus(br));
  mem_bus_arbiter #(.RR_EN(1'b0)) dut_fp (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bf));

  typedef struct {
    int          cyc;
    logic [1:0]  rv;
    logic [31:0] rd;
    logic        err;
  } resp_t;

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [6:0]  exp_req;
    int          lat;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  resp_t sb[$];
  vec_t  vecs[14];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every rvalid of the round-robin instance must match the queue head
  always @(negedge clk_i) begin
    resp_t e;
    if (rst_ni && br.rvalid_o != 2'b00) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_rvalid: got rvalid %b, expected none (cycle %0d)", br.rvalid_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_cycle", 128'(cyc), 128'(e.cyc));
        chk("rvalid", 128'(br.rvalid_o), 128'(e.rv));
        chk("rdata", 128'(br.rdata_o), 128'(e.rd));
        chk("err", 128'(br.err_o), 128'(e.err));
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, {br.gnt_o, br.rvalid_o, br.err_o, br.slv_req_o, br.slv_we_o, br.slv_be_o,
               br.rdata_o, br.slv_addr_o, br.slv_wdata_o}, 128'h0);
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    resp_t e;
    @(posedge clk_i); #1;
    br.addr_i[v.m]  = v.addr;
    br.we_i[v.m]    = v.we;
    br.be_i[v.m]    = v.be;
    br.wdata_i[v.m] = v.wdata;
    br.req_i        = v.m ? 2'b10 : 2'b01;
    #1;
    t = cyc;
    chk("gnt", 128'(br.gnt_o), 128'(v.m ? 2'b10 : 2'b01));
    @(negedge clk_i);
    chk("slv_req_at_grant", 128'(br.slv_req_o), 128'h0);
    @(posedge clk_i); #1;
    br.req_i = 2'b00;
    e.cyc = t + 2 + v.lat;
    e.rv  = v.m ? 2'b10 : 2'b01;
    e.rd  = v.exp_rd;
    e.err = v.exp_err;
    sb.push_back(e);
    for (int c = t + 1; c <= t + 2 + v.lat; c++) begin
      @(negedge clk_i);
      chk((c == t + 1) ? "slv_req_issue" : "slv_req_quiet", 128'(br.slv_req_o),
          128'((c == t + 1) ? v.exp_req : 7'h00));
      chk("slv_fields", {br.slv_addr_o, br.slv_we_o, br.slv_be_o, br.slv_wdata_o},
          {v.addr, v.we, v.be, v.wdata});
    end
    @(posedge clk_i); #1;
    chk("resp_seen", 128'(sb.size()), 128'h0);
  endtask

  task automatic reset_mid_access();
    int t;
    int n_rv;
    @(posedge clk_i); #1;
    br.addr_i[0] = 32'h1C00_0010;
    br.we_i[0]   = 1'b0;
    br.be_i[0]   = 4'hF;
    br.req_i     = 2'b01;
    t = cyc;
    @(posedge clk_i); #1;
    br.req_i = 2'b00;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_at_cycle", 128'(cyc), 128'(t + 4));
    rst_ni = 1'b0;
    #1;
    chk_all_zero("outputs_in_reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    n_rv = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (br.rvalid_o != 2'b00) n_rv++;
    end
    chk("no_rvalid_after_reset", 128'(n_rv), 128'h0);
  endtask

  // Both masters requesting: model alternates M0 (gpio, lat 0) and M1 (bootrom, lat 1)
  task automatic rr_seq();
    int t, next_g, lat;
    logic who;
    logic [1:0] exp_g;
    resp_t e;
    @(posedge clk_i); #1;
    br.addr_i[0] = 32'h1B00_1000; br.we_i[0] = 1'b0; br.be_i[0] = 4'hF;
    br.addr_i[1] = 32'h1A00_0000; br.we_i[1] = 1'b0; br.be_i[1] = 4'hF;
    br.req_i = 2'b11;
    t = cyc;
    next_g = t;
    who = 1'b0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk_i);
      exp_g = 2'b00;
      if (cyc == next_g) exp_g = who ? 2'b10 : 2'b01;
      chk("rr_gnt", 128'(br.gnt_o), 128'(exp_g));
      if (cyc == next_g) begin
        lat   = who ? 1 : 0;
        e.cyc = cyc + 2 + lat;
        e.rv  = exp_g;
        e.rd  = who ? 32'hB007_0000 : 32'h6910_0002;
        e.err = 1'b0;
        sb.push_back(e);
        next_g = cyc + 2 + lat;
        who = !who;
      end
    end
    @(posedge clk_i); #1;
    br.req_i = 2'b00;
    repeat (6) @(posedge clk_i);
    #1;
    chk("rr_all_resp", 128'(sb.size()), 128'h0);
  endtask

  task automatic fp_seq();
    bit found;
    @(posedge clk_i); #1;
    bf.addr_i[0] = 32'h1B00_1000; bf.we_i[0] = 1'b0; bf.be_i[0] = 4'hF;
    bf.addr_i[1] = 32'h1A00_0000; bf.we_i[1] = 1'b0; bf.be_i[1] = 4'hF;
    bf.req_i = 2'b11;
    #1;
    chk("fp_first_gnt", 128'(bf.gnt_o), 128'(2'b01));
    repeat (12) begin
      @(negedge clk_i);
      chk("fp_m1_starved", 128'(bf.gnt_o[1]), 128'h0);
    end
    @(posedge clk_i); #1;
    bf.req_i = 2'b10;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk_i);
      if (bf.gnt_o == 2'b10) found = 1'b1;
    end
    chk("fp_m1_gets_bus", 128'(found), 128'h1);
    @(posedge clk_i); #1;
    bf.req_i = 2'b00;
    repeat (4) @(posedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h1C00_0010, 1'b0, 4'hF, 32'h0,         7'b0100000, 7, 32'hCAFE_F00D, 1'b0};
    vecs[1]  = '{1'b1, 32'h1A00_2000, 1'b0, 4'hF, 32'h0,         7'b0000000, 0, 32'h0,         1'b1};
    vecs[2]  = '{1'b0, 32'h1D03_FFFC, 1'b1, 4'h3, 32'h1234_5678, 7'b1000000, 3, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h1A00_0000, 1'b0, 4'hF, 32'h0,         7'b0000001, 1, 32'hB007_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h1A00_1FFF, 1'b0, 4'h1, 32'h0,         7'b0000001, 1, 32'hB007_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h1B00_4000, 1'b0, 4'hF, 32'h0,         7'b0000000, 0, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h1B00_0FFC, 1'b0, 4'hF, 32'h0,         7'b0000010, 0, 32'h50C0_0001, 1'b0};
    vecs[7]  = '{1'b0, 32'h1B00_2000, 1'b0, 4'hF, 32'h0,         7'b0001000, 0, 32'h7133_0003, 1'b0};
    vecs[8]  = '{1'b1, 32'h1B00_3FFC, 1'b0, 4'hF, 32'h0,         7'b0010000, 0, 32'h9E30_0004, 1'b0};
    vecs[9]  = '{1'b0, 32'h1D00_0000, 1'b0, 4'hF, 32'h0,         7'b1000000, 3, 32'hFB00_0006, 1'b0};
    vecs[10] = '{1'b1, 32'h1C00_FFFC, 1'b1, 4'hF, 32'hA5A5_A5A5, 7'b0100000, 7, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h1B00_1FFC, 1'b0, 4'hF, 32'h0,         7'b0000100, 0, 32'h6910_0002, 1'b0};
    vecs[12] = '{1'b0, 32'h19FF_FFFC, 1'b1, 4'h1, 32'hDEAD_BEEF, 7'b0000000, 0, 32'h0,         1'b1};
    vecs[13] = '{1'b1, 32'h1D04_0000, 1'b0, 4'hF, 32'h0,         7'b0000000, 0, 32'h0,         1'b1};

    br.req_i = 2'b00; br.addr_i = '0; br.we_i = 2'b00; br.be_i = '0; br.wdata_i = '0;
    bf.req_i = 2'b00; bf.addr_i = '0; bf.we_i = 2'b00; bf.be_i = '0; bf.wdata_i = '0;
    br.slv_rdata_i[0] = 32'hB007_0000; br.slv_rdata_i[1] = 32'h50C0_0001;
    br.slv_rdata_i[2] = 32'h6910_0002; br.slv_rdata_i[3] = 32'h7133_0003;
    br.slv_rdata_i[4] = 32'h9E30_0004; br.slv_rdata_i[5] = 32'hCAFE_F00D;
    br.slv_rdata_i[6] = 32'hFB00_0006;
    bf.slv_rdata_i = br.slv_rdata_i;

    #3;
    chk_all_zero("reset_state");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);
    reset_mid_access();
    rr_seq();
    fp_seq();

    chk("scoreboard_drained", 128'(sb.size()), 128'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
